// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank controller: opcode and FSM encodings,
// default bank sizing, and the JK next-state function used by every cell.
package jk_ctrl_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned N_FF_DEF  = 8;
  localparam int unsigned SEL_W_DEF = 3;

  // Opcode bit 1 is J, bit 0 is K.
  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_SET  = 2'b10,
    OP_TOG  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      default: r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Requester-side bus of the JK bank controller: request levels, opcodes,
// target cell selects and the returned completion grants.
interface jk_bank_ctrl_if
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
);

  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [SEL_W*N_REQ-1:0] sel;
  logic [N_REQ-1:0]       gnt;

  modport master (output req, op, sel, input gnt);
  modport slave  (input req, op, sel, output gnt);

endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset.
module jk_cell
  import jk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 1'b0;
    else     q <= jk_next(q, j, k);
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Round-robin arbitrated controller for a bank of JK cells: one requester at a
// time gets its opcode applied to its chosen cell, then holds a grant until it drops req.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned N_FF  = N_FF_DEF,
  parameter int unsigned SEL_W = SEL_W_DEF
)(
  input  logic            clk,
  input  logic            rst,
  jk_bank_ctrl_if.slave   bus,
  output logic [N_FF-1:0] q,
  output logic            busy
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] pick;
  logic             found;
  op_t              lop;
  logic [SEL_W-1:0] lsel;
  logic [N_FF-1:0]  j;
  logic [N_FF-1:0]  k;

  // First set request at or above the pointer, wrapping past N_REQ-1.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned o = 0; o < N_REQ; o++) begin
      idx = (32'(ptr) + o) % N_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (found) state_nxt = ST_DRIVE;
      ST_DRIVE: state_nxt = ST_ACK;
      ST_ACK:   if (!bus.req[win]) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Winner context is captured once per arbitration so later op/sel changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      win  <= '0;
      lop  <= OP_HOLD;
      lsel <= '0;
    end else begin
      if (state == ST_IDLE && found) begin
        win  <= pick;
        lop  <= op_t'(bus.op[2*pick +: 2]);
        lsel <= bus.sel[SEL_W*pick +: SEL_W];
      end
      if (state == ST_ACK && !bus.req[win])
        ptr <= (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
  end

  always_comb begin
    bus.gnt = '0;
    busy    = (state != ST_IDLE);
    j       = '0;
    k       = '0;
    if (state == ST_ACK)
      bus.gnt[win] = 1'b1;
    if (state == ST_DRIVE) begin
      for (int unsigned f = 0; f < N_FF; f++) begin
        if (32'(lsel) == f) begin
          j[f] = lop[1];
          k[f] = lop[0];
        end
      end
    end
  end

  for (genvar f = 0; f < N_FF; f++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[f]),
      .k   (k[f]),
      .q   (q[f])
    );
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
  a_gnt_only_ack: assert property (@(posedge clk) disable iff (rst)
                                   (state != ST_ACK) |-> (bus.gnt == '0));

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed self-checking bench for jk_bank_ctrl with hand-computed expectations.
module tb_jk_bank_ctrl;
  import jk_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] q;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  jk_bank_ctrl_if #(.N_REQ(4), .SEL_W(3)) bus ();

  jk_bank_ctrl #(.N_REQ(4), .N_FF(8), .SEL_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .q    (q),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input op_t o, input int s);
    bus.op[2*i +: 2]  = o;
    bus.sel[3*i +: 3] = 3'(s);
    bus.req[i]        = 1'b1;
  endtask

  // Wait (bounded) for a grant, check it and q, then release and check the return to idle.
  task automatic serve(input string tag, input int i, input logic [3:0] eg, input logic [7:0] eq);
    int n;
    n = 0;
    while (bus.gnt == 4'b0000 && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".gnt"}, 32'(bus.gnt), 32'(eg));
    check({tag, ".q"}, 32'(q), 32'(eq));
    bus.req[i] = 1'b0;
    tick();
    check({tag, ".gnt_off"}, 32'(bus.gnt), 32'h0);
    check({tag, ".idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    bus.req = '0;
    bus.op  = '0;
    bus.sel = '0;

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1;
    check("rst.q", 32'(q), 32'h00);
    check("rst.gnt", 32'(bus.gnt), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rel.q", 32'(q), 32'h00);
    check("rel.busy", 32'(busy), 32'h0);
    tick();

    // single request: SET cell 5
    set_req(0, OP_SET, 5);
    tick();
    check("single.e0.busy", 32'(busy), 32'h1);
    check("single.e0.gnt", 32'(bus.gnt), 32'h0);
    check("single.e0.q", 32'(q), 32'h00);
    tick();
    check("single.e1.q", 32'(q), 32'h20);
    check("single.e1.gnt", 32'(bus.gnt), 32'h1);
    tick();
    check("single.hold.gnt", 32'(bus.gnt), 32'h1);
    check("single.hold.busy", 32'(busy), 32'h1);
    bus.req[0] = 1'b0;
    tick();
    check("single.end.gnt", 32'(bus.gnt), 32'h0);
    check("single.end.busy", 32'(busy), 32'h0);
    check("single.end.q", 32'(q), 32'h20);

    // reset to bring the pointer back to 0 and clear the bank
    rst = 1'b1;
    #1;
    check("rst2.q", 32'(q), 32'h00);
    tick();
    rst = 1'b0;
    tick();

    // contention: all toggle distinct cells, served 0,1,2,3
    for (int i = 0; i < 4; i++) set_req(i, OP_TOG, i);
    serve("rr0", 0, 4'b0001, 8'h01);
    serve("rr1", 1, 4'b0010, 8'h03);
    serve("rr2", 2, 4'b0100, 8'h07);
    serve("rr3", 3, 4'b1000, 8'h0F);

    // pointer wrap, then an immediate re-request yields to requester 3
    set_req(0, OP_CLR, 0);
    set_req(3, OP_SET, 7);
    serve("wrap0", 0, 4'b0001, 8'h0E);
    bus.req[0] = 1'b1;
    serve("wrap3", 3, 4'b1000, 8'h8E);
    serve("wrap0b", 0, 4'b0001, 8'h8E);

    // early drop during DRIVE, with op/sel changes that must be ignored
    set_req(1, OP_CLR, 1);
    tick();
    check("drop.drive.busy", 32'(busy), 32'h1);
    check("drop.drive.gnt", 32'(bus.gnt), 32'h0);
    bus.req[1]    = 1'b0;
    bus.op[3:2]   = OP_SET;
    bus.sel[5:3]  = 3'd2;
    tick();
    check("drop.ack.gnt", 32'(bus.gnt), 32'h2);
    check("drop.ack.q", 32'(q), 32'h8C);
    tick();
    check("drop.end.gnt", 32'(bus.gnt), 32'h0);
    check("drop.end.busy", 32'(busy), 32'h0);
    check("drop.end.q", 32'(q), 32'h8C);

    // reset while in ACK, requester 2 re-served afterwards
    set_req(2, OP_SET, 4);
    tick();
    tick();
    check("rack.gnt", 32'(bus.gnt), 32'h4);
    check("rack.q", 32'(q), 32'h9C);
    #2 rst = 1'b1;
    #1;
    check("rack.rst.gnt", 32'(bus.gnt), 32'h0);
    check("rack.rst.q", 32'(q), 32'h00);
    check("rack.rst.busy", 32'(busy), 32'h0);
    tick();
    check("rack.held.busy", 32'(busy), 32'h0);
    check("rack.held.q", 32'(q), 32'h00);
    rst = 1'b0;
    #1;
    check("rack.rel.q", 32'(q), 32'h00);
    serve("rack.reserve", 2, 4'b0100, 8'h10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
